// File: rtl/core_pipe_pkg.sv
// Shared definitions for the core pipeline registers: ctrl bundle layout and
// the handshake state encoding.
package core_pipe_pkg;

  localparam int unsigned CTRL_W = 8;

  // Bit positions inside the {MemtoReg, RegWrite, Branch, MemRead, MemWrite, ALUSrc, ALUOp} bundle.
  localparam int unsigned CTRL_MEMTOREG = 7;
  localparam int unsigned CTRL_REGWRITE = 6;
  localparam int unsigned CTRL_BRANCH   = 5;
  localparam int unsigned CTRL_MEMREAD  = 4;
  localparam int unsigned CTRL_MEMWRITE = 3;
  localparam int unsigned CTRL_ALUSRC   = 2;
  localparam int unsigned CTRL_ALUOP_HI = 1;
  localparam int unsigned CTRL_ALUOP_LO = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_payload_reg.sv
// One ID/EX payload entry: loads the whole instruction on load, and clear wipes
// only the ctrl bundle so a squashed entry degrades to a NOP.
module pipe_payload_reg
  import core_pipe_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned RIDX_W  = 5,
  parameter int unsigned FUNCT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clr,
  input  logic [XLEN-1:0]    new_pc,
  input  logic [XLEN-1:0]    new_rs1_data,
  input  logic [XLEN-1:0]    new_rs2_data,
  input  logic [XLEN-1:0]    new_imm,
  input  logic [RIDX_W-1:0]  new_rs1,
  input  logic [RIDX_W-1:0]  new_rs2,
  input  logic [RIDX_W-1:0]  new_rd,
  input  logic [FUNCT_W-1:0] new_funct,
  input  logic [CTRL_W-1:0]  new_ctrl,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    rs1_data,
  output logic [XLEN-1:0]    rs2_data,
  output logic [XLEN-1:0]    imm,
  output logic [RIDX_W-1:0]  rs1,
  output logic [RIDX_W-1:0]  rs2,
  output logic [RIDX_W-1:0]  rd,
  output logic [FUNCT_W-1:0] funct,
  output logic [CTRL_W-1:0]  ctrl
);

  // Data fields: plain load-enable register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc       <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
      imm      <= '0;
      rs1      <= '0;
      rs2      <= '0;
      rd       <= '0;
      funct    <= '0;
    end else if (load) begin
      pc       <= new_pc;
      rs1_data <= new_rs1_data;
      rs2_data <= new_rs2_data;
      imm      <= new_imm;
      rs1      <= new_rs1;
      rs2      <= new_rs2;
      rd       <= new_rd;
      funct    <= new_funct;
    end
  end

  // Ctrl bundle: clear wins over load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl <= '0;
    end else if (clr) begin
      ctrl <= '0;
    end else if (load) begin
      ctrl <= new_ctrl;
    end
  end

endmodule

// File: rtl/idex_pipe_stage.sv
// ID/EX pipeline stage with valid/ready handshake, one-entry skid buffer,
// branch-squash flush and a saturating stall counter.
module idex_pipe_stage
  import core_pipe_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned RIDX_W  = 5,
  parameter int unsigned FUNCT_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [RIDX_W-1:0]  in_rs1,
  input  logic [RIDX_W-1:0]  in_rs2,
  input  logic [RIDX_W-1:0]  in_rd,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic [CTRL_W-1:0]  in_ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_rs1_data,
  output logic [XLEN-1:0]    out_rs2_data,
  output logic [XLEN-1:0]    out_imm,
  output logic [RIDX_W-1:0]  out_rs1,
  output logic [RIDX_W-1:0]  out_rs2,
  output logic [RIDX_W-1:0]  out_rd,
  output logic [FUNCT_W-1:0] out_funct,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  logic   accept, issue;
  logic   load_main, load_skid, from_skid;

  logic [XLEN-1:0]    skid_pc, skid_rs1_data, skid_rs2_data, skid_imm;
  logic [RIDX_W-1:0]  skid_rs1, skid_rs2, skid_rd;
  logic [FUNCT_W-1:0] skid_funct;
  logic [CTRL_W-1:0]  skid_ctrl, main_ctrl;

  assign accept = in_valid & in_ready;
  assign issue  = out_valid & out_ready;

  // Entry load strobes; flush suppresses every load.
  always_comb begin
    load_main = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    if (!flush) begin
      case (state)
        ST_EMPTY: load_main = accept;
        ST_BUSY: begin
          load_main = issue & accept;
          load_skid = accept & ~issue;
        end
        ST_FULL: begin
          load_main = issue;
          from_skid = issue;
        end
        default: ;
      endcase
    end
  end

  // Handshake FSM; out_valid and in_ready are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state     <= ST_BUSY;
            out_valid <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (issue && !accept) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end else if (accept && !issue) begin
            state    <= ST_FULL;
            in_ready <= 1'b0;
          end
        end
        ST_FULL: begin
          if (issue) begin
            state    <= ST_BUSY;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  pipe_payload_reg #(.XLEN(XLEN), .RIDX_W(RIDX_W), .FUNCT_W(FUNCT_W)) u_skid (
    .clk          (clk),
    .reset        (reset),
    .load         (load_skid),
    .clr          (flush),
    .new_pc       (in_pc),
    .new_rs1_data (in_rs1_data),
    .new_rs2_data (in_rs2_data),
    .new_imm      (in_imm),
    .new_rs1      (in_rs1),
    .new_rs2      (in_rs2),
    .new_rd       (in_rd),
    .new_funct    (in_funct),
    .new_ctrl     (in_ctrl),
    .pc           (skid_pc),
    .rs1_data     (skid_rs1_data),
    .rs2_data     (skid_rs2_data),
    .imm          (skid_imm),
    .rs1          (skid_rs1),
    .rs2          (skid_rs2),
    .rd           (skid_rd),
    .funct        (skid_funct),
    .ctrl         (skid_ctrl)
  );

  // Main entry refills from the skid when draining FULL, else from ID.
  pipe_payload_reg #(.XLEN(XLEN), .RIDX_W(RIDX_W), .FUNCT_W(FUNCT_W)) u_main (
    .clk          (clk),
    .reset        (reset),
    .load         (load_main),
    .clr          (flush),
    .new_pc       (from_skid ? skid_pc       : in_pc),
    .new_rs1_data (from_skid ? skid_rs1_data : in_rs1_data),
    .new_rs2_data (from_skid ? skid_rs2_data : in_rs2_data),
    .new_imm      (from_skid ? skid_imm      : in_imm),
    .new_rs1      (from_skid ? skid_rs1      : in_rs1),
    .new_rs2      (from_skid ? skid_rs2      : in_rs2),
    .new_rd       (from_skid ? skid_rd       : in_rd),
    .new_funct    (from_skid ? skid_funct    : in_funct),
    .new_ctrl     (from_skid ? skid_ctrl     : in_ctrl),
    .pc           (out_pc),
    .rs1_data     (out_rs1_data),
    .rs2_data     (out_rs2_data),
    .imm          (out_imm),
    .rs1          (out_rs1),
    .rs2          (out_rs2),
    .rd           (out_rd),
    .funct        (out_funct),
    .ctrl         (main_ctrl)
  );

  // Stale ctrl left in main after a drain must read as a NOP bubble.
  assign out_ctrl = out_valid ? main_ctrl : '0;

  // Saturating count of cycles EX back-pressures a valid instruction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_idex_pipe_stage.sv
// Self-checking bench for idex_pipe_stage: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_idex_pipe_stage;
  import core_pipe_pkg::*;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned RIDX_W  = 5;
  localparam int unsigned FUNCT_W = 4;
  localparam int unsigned CNT_W   = 2;

  typedef struct {
    logic [XLEN-1:0]    pc, rs1_data, rs2_data, imm;
    logic [RIDX_W-1:0]  rs1, rs2, rd;
    logic [FUNCT_W-1:0] funct;
    logic [CTRL_W-1:0]  ctrl;
  } entry_t;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0]    in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [RIDX_W-1:0]  in_rs1, in_rs2, in_rd;
  logic [FUNCT_W-1:0] in_funct;
  logic [CTRL_W-1:0]  in_ctrl;
  logic [XLEN-1:0]    out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [RIDX_W-1:0]  out_rs1, out_rs2, out_rd;
  logic [FUNCT_W-1:0] out_funct;
  logic [CTRL_W-1:0]  out_ctrl;
  logic [CNT_W-1:0]   stall_cnt;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  idex_pipe_stage #(.XLEN(XLEN), .RIDX_W(RIDX_W), .FUNCT_W(FUNCT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_funct(in_funct), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct(out_funct), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the instructions held, oldest first, plus the payload last shown.
  entry_t q[$];
  entry_t last;
  int     m_cnt;

  function automatic entry_t cur_in();
    entry_t e;
    e.pc = in_pc; e.rs1_data = in_rs1_data; e.rs2_data = in_rs2_data; e.imm = in_imm;
    e.rs1 = in_rs1; e.rs2 = in_rs2; e.rd = in_rd; e.funct = in_funct; e.ctrl = in_ctrl;
    return e;
  endfunction

  always @(posedge clk) begin
    bit ov, ir;
    if (!reset) begin
      q.delete();
      last  = '{default: '0};
      m_cnt = 0;
    end else begin
      ov = (q.size() != 0);
      ir = (q.size() < 2);
      if (ov && !out_ready && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        if (ov && out_ready) void'(q.pop_front());
        if (in_valid && ir) q.push_back(cur_in());
      end
      if (q.size() != 0) last = q[0];
    end
  end

  // Compare every output against the model each cycle, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      check("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("m_in_ready",  64'(in_ready),  64'(q.size() < 2));
      check("m_out_pc",    out_pc,         last.pc);
      check("m_rs1_data",  out_rs1_data,   last.rs1_data);
      check("m_rs2_data",  out_rs2_data,   last.rs2_data);
      check("m_imm",       out_imm,        last.imm);
      check("m_rs1",       64'(out_rs1),   64'(last.rs1));
      check("m_rs2",       64'(out_rs2),   64'(last.rs2));
      check("m_rd",        64'(out_rd),    64'(last.rd));
      check("m_funct",     64'(out_funct), 64'(last.funct));
      check("m_ctrl",      64'(out_ctrl),  (q.size() != 0) ? 64'(last.ctrl) : 64'd0);
      check("m_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic fl, input logic v, input logic [XLEN-1:0] pc,
                       input logic ordy);
    reset = rst; flush = fl; in_valid = v; out_ready = ordy;
    in_pc       = pc;
    in_rs1_data = (pc * 3) ^ 64'h0123_4567_89ab_cdef;
    in_rs2_data = pc + 64'h1111;
    in_imm      = ~pc;
    in_rs1      = RIDX_W'(pc >> 2);
    in_rs2      = RIDX_W'(pc >> 3);
    in_rd       = RIDX_W'(pc >> 4);
    in_funct    = FUNCT_W'(pc >> 2);
    in_ctrl     = CTRL_W'(pc >> 2) | 8'h01;
  endtask

  initial begin
    // Reset held two cycles with in_valid high.
    drive(1'b0, 1'b0, 1'b1, 64'h55, 1'b1);
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_pc",    out_pc,         64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    checking = 1'b1;

    // Streaming at full rate.
    drive(1'b1, 1'b0, 1'b1, 64'h100, 1'b1); tick();
    check("str_pc0", out_pc, 64'h100);
    check("str_ctrl0", 64'(out_ctrl), 64'h41);
    drive(1'b1, 1'b0, 1'b1, 64'h104, 1'b1); tick();
    check("str_pc1", out_pc, 64'h104);
    check("str_rdy1", 64'(in_ready), 64'd1);
    drive(1'b1, 1'b0, 1'b1, 64'h108, 1'b1); tick();
    check("str_pc2", out_pc, 64'h108);
    check("str_rd2", 64'(out_rd), 64'h10);
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b1); tick();
    check("str_drain_valid", 64'(out_valid), 64'd0);
    check("str_drain_ctrl", 64'(out_ctrl), 64'd0);

    // Skid: 0x200 held, 0x204 captured into skid, 0x208 ignored while FULL.
    drive(1'b1, 1'b0, 1'b1, 64'h200, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b1, 64'h204, 1'b0); tick();
    check("skid_in_ready", 64'(in_ready), 64'd0);
    check("skid_hold_pc",  out_pc,        64'h200);
    check("skid_cnt",      64'(stall_cnt), 64'd1);
    drive(1'b1, 1'b0, 1'b1, 64'h208, 1'b1); tick();
    check("skid_issue2_pc", out_pc, 64'h204);
    check("skid_rdy_back",  64'(in_ready), 64'd1);
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b1); tick();
    check("skid_empty", 64'(out_valid), 64'd0);

    // Flush while FULL, racing an incoming 0x300.
    drive(1'b1, 1'b0, 1'b1, 64'h280, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b1, 64'h284, 1'b0); tick();
    check("fl_full", 64'(in_ready), 64'd0);
    drive(1'b1, 1'b1, 1'b1, 64'h300, 1'b0); tick();
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ctrl",  64'(out_ctrl),  64'd0);
    check("fl_pc_hold", out_pc, 64'h280);
    check("fl_cnt", 64'(stall_cnt), 64'd3);
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b1); tick();
    check("fl_not_captured", 64'(out_valid), 64'd0);

    // Saturating stall counter from a fresh reset.
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1); tick();
    check("sc_rst", 64'(stall_cnt), 64'd0);
    drive(1'b1, 1'b0, 1'b1, 64'h400, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("sc_seq", 64'(stall_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
    end
    drive(1'b1, 1'b1, 1'b0, 64'h0, 1'b0); tick();
    check("sc_after_flush", 64'(stall_cnt), 64'd3);

    // Reset mid-operation discards held work; reset beats a simultaneous flush.
    drive(1'b1, 1'b0, 1'b1, 64'h500, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b1, 64'h504, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 64'h508, 1'b0); tick();
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_ready", 64'(in_ready),  64'd1);
    check("mr_pc",    out_pc,         64'd0);
    check("mr_cnt",   64'(stall_cnt), 64'd0);

    // Mixed traffic with irregular back-pressure, checked by the model only.
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, (i % 23) == 22, ((i * 7) % 5) != 0, 64'h1000 + 64'(4 * i), ((i * 3) % 4) != 1);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    tick(); tick(); tick();
    check("end_drained", 64'(out_valid), 64'd0);

    @(posedge clk);
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idex_pipe_stage.md
# idex_pipe_stage

Parametrised ID/EX pipeline stage for the 5-stage core, replacing the fixed always-load ID/EX register. It carries PC, operands, immediate, register indices, funct and the EX/MEM/WB control bundle from decode into execute. It adds a valid/ready handshake with a one-entry skid buffer, so a stalled EX does not drop an instruction, plus a flush input for branch squash and a saturating stall counter.

## Interface
- `XLEN`, 64: width of PC, operand and immediate fields.
- `RIDX_W`, 5: register index width.
- `FUNCT_W`, 4: funct field width.
- `CNT_W`, 16: stall counter width.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-low; sampled on posedge `clk`, `reset==0` clears state.
- `flush` in 1: squash all held instructions.
- `in_valid` in 1 / `in_ready` out 1: upstream (ID) handshake.
- `in_pc`, `in_rs1_data`, `in_rs2_data`, `in_imm` in XLEN each: payload.
- `in_rs1`, `in_rs2`, `in_rd` in RIDX_W each; `in_funct` in FUNCT_W.
- `in_ctrl` in 8: control bundle {MemtoReg, RegWrite, Branch, MemRead, MemWrite, ALUSrc, ALUOp[1:0]}, MSB first.
- `out_valid` out 1 / `out_ready` in 1: downstream (EX) handshake.
- `out_pc`, `out_rs1_data`, `out_rs2_data`, `out_imm`, `out_rs1`, `out_rs2`, `out_rd`, `out_funct`, `out_ctrl`: registered payload, same widths as the inputs.
- `stall_cnt` out CNT_W: count of cycles with `out_valid & ~out_ready`.

## Operation
- Storage: main entry (drives outputs) plus skid entry. Each entry holds the full payload.
- State: EMPTY (no entry valid), BUSY (main valid), FULL (main and skid valid).
- `in_ready = (state != FULL)`. This is a pure function of registered state and has no combinational path from `out_ready`.
- `out_valid = (state != EMPTY)`. `out_ctrl` is forced to 0 whenever `out_valid==0`, so EX sees a NOP bubble.
- Accept means `in_valid & in_ready`. Issue means `out_valid & out_ready`.
- EMPTY: on accept, load main and go to BUSY.
- BUSY with issue and accept: load main and stay in BUSY.
- BUSY with issue and no accept: go to EMPTY.
- BUSY with accept and no issue: load skid and go to FULL.
- BUSY with neither: hold.
- FULL with issue: main takes skid and the state goes to BUSY. `in_valid` is ignored in FULL.
- FULL with no issue: hold.
- Flush (`flush==1`, `reset==1`): next state is EMPTY and the stored ctrl in both entries is zeroed. It overrides any accept or issue in the same cycle. Data fields hold their previous values.
- stall_cnt: increments by 1 each cycle `out_valid & ~out_ready`, saturates at 2^CNT_W−1. It is not cleared by flush.
- Reset (`reset==0`) takes priority over everything: state EMPTY, all payload registers 0, stall_cnt 0.
- Reset values of outputs: `out_valid` 0, `in_ready` 1, all `out_*` payload 0, `stall_cnt` 0.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N appears on `out_*` after edge N with `out_valid=1`.
- Throughput: 1 instruction/cycle while `out_ready=1`.
- Stall: `in_ready` deasserts only after the second instruction is captured, one cycle after `out_ready` drops. No instruction is lost or duplicated.
- `out_*` are stable while `out_valid & ~out_ready`.
- Reset mid-operation: held instructions are discarded at the edge where `reset==0` is sampled, and handshake outputs are at reset values after that edge.
- Simultaneous flush and reset: reset wins, with the same result except that stall_cnt is cleared.

## Structure
- Shared package `core_pipe_pkg`:
  - ctrl bundle bit-position constants and the `CTRL_W=8` constant;
  - state encodings ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2.
- One sub-module `pipe_payload_reg`: a parametrised payload register with load enable, ctrl clear, and synchronous active-low reset. It is instantiated twice (main and skid).
- Top level holds the FSM, the output ctrl gating and stall_cnt.

## Test plan
- Reset: drive `reset=0` for 2 cycles with `in_valid=1` → `out_valid=0`, `in_ready=1`, `out_pc=0`, `stall_cnt=0`.
- Streaming: PCs 0x100, 0x104 and 0x108 on consecutive cycles with `out_ready=1` → each appears one cycle later in order, with `in_ready` held at 1.
- Skid:
  - Setup: 0x200 is in BUSY, then `out_ready=0` while 0x204 is presented.
  - Expected: the state goes to FULL, `in_ready=0`, and `out_pc` holds 0x200.
  - After `out_ready=1`: 0x200 issues, then 0x204 issues, with no loss.
- Flush: in FULL, assert `flush=1` together with `in_valid=1` (PC 0x300) → next cycle `out_valid=0`, `out_ctrl=0`, and 0x300 is not captured.
- Stall counter: set CNT_W=2 and hold `out_valid=1`, `out_ready=0` for 5 cycles → `stall_cnt` reads 1, 2, 3, 3, 3. A following flush leaves it at 3.
